// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch: issues to the I-cache, consults the predictor and
// hands {ins, pc, jump} to the dispatcher. Optional macro FETCH_JALR_STALL_EN stalls after JALR.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INS_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_valid,
    input  logic [INS_W-1:0]  icache_ins,
    output logic [ADDR_W-1:0] pred_pc_cur,
    output logic [INS_W-1:0]  pred_ins_cur,
    input  logic [ADDR_W-1:0] pred_pc_next,
    input  logic              pred_jump,
    input  logic              iq_full,
    output logic              out_valid,
    output logic [INS_W-1:0]  out_ins,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_pred_jump,
    input  logic              rob_flush,
    input  logic [ADDR_W-1:0] rob_flush_pc
);

    typedef enum logic [2:0] {StIdle, StFetch, StHold, StDrain, StWaitJalr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] stale_addr_q, stale_addr_d;
    logic [INS_W-1:0]  hold_ins_q, hold_ins_d;
    logic [ADDR_W-1:0] hold_next_pc_q, hold_next_pc_d;
    logic              hold_jump_q, hold_jump_d;
    logic              jalr_live, jalr_held;

`ifdef FETCH_JALR_STALL_EN
    assign jalr_live = (icache_ins[6:0] == 7'b1100111);
    assign jalr_held = (hold_ins_q[6:0] == 7'b1100111);
`else
    assign jalr_live = 1'b0;
    assign jalr_held = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        stale_addr_d   = stale_addr_q;
        hold_ins_d     = hold_ins_q;
        hold_next_pc_d = hold_next_pc_q;
        hold_jump_d    = hold_jump_q;

        icache_req    = (state_q == StFetch) || (state_q == StDrain);
        icache_addr   = (state_q == StDrain) ? stale_addr_q : pc_q;
        pred_pc_cur   = pc_q;
        pred_ins_cur  = (state_q == StHold) ? hold_ins_q : icache_ins;
        out_valid     = 1'b0;
        out_ins       = '0;
        out_pc        = '0;
        out_pred_jump = 1'b0;

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (icache_valid) begin
                    out_ins       = icache_ins;
                    out_pc        = pc_q;
                    out_pred_jump = pred_jump;
                    out_valid     = !iq_full;
                    if (!iq_full) begin
                        pc_d    = pred_pc_next;
                        state_d = jalr_live ? StWaitJalr : StFetch;
                    end else begin
                        hold_ins_d     = icache_ins;
                        hold_next_pc_d = pred_pc_next;
                        hold_jump_d    = pred_jump;
                        state_d        = StHold;
                    end
                end
            end
            StHold: begin
                out_ins       = hold_ins_q;
                out_pc        = pc_q;
                out_pred_jump = hold_jump_q;
                out_valid     = !iq_full;
                if (!iq_full) begin
                    pc_d    = hold_next_pc_q;
                    state_d = jalr_held ? StWaitJalr : StIdle;
                end
            end
            StDrain: begin
                if (icache_valid) state_d = StIdle;
            end
            StWaitJalr: state_d = StWaitJalr;
            default: state_d = StIdle;
        endcase

        // Redirect wins over everything else this cycle.
        if (rob_flush) begin
            out_valid      = 1'b0;
            pc_d           = rob_flush_pc;
            hold_ins_d     = '0;
            hold_next_pc_d = '0;
            hold_jump_d    = 1'b0;
            if (state_q == StFetch) begin
                stale_addr_d = pc_q;
                state_d      = icache_valid ? StIdle : StDrain;
            end else if (state_q == StDrain) begin
                // A response landing with the flush still retires the stale request.
                state_d = icache_valid ? StIdle : StDrain;
            end else begin
                state_d = StIdle;
            end
        end

        if (!rdy) out_valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            pc_q           <= RESET_PC;
            stale_addr_q   <= '0;
            hold_ins_q     <= '0;
            hold_next_pc_q <= '0;
            hold_jump_q    <= 1'b0;
        end else if (rdy) begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            stale_addr_q   <= stale_addr_d;
            hold_ins_q     <= hold_ins_d;
            hold_next_pc_q <= hold_next_pc_d;
            hold_jump_q    <= hold_jump_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand sequences for flush/stall/wrap/JALR,
// then randomized traffic checked against a transaction-level model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        icache_req, icache_valid;
    logic [31:0] icache_addr, icache_ins;
    logic [31:0] pred_pc_cur, pred_ins_cur, pred_pc_next;
    logic        pred_jump, iq_full;
    logic        out_valid, out_pred_jump;
    logic [31:0] out_ins, out_pc;
    logic        rob_flush;
    logic [31:0] rob_flush_pc;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W  (32),
        .INS_W   (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_valid (icache_valid),
        .icache_ins   (icache_ins),
        .pred_pc_cur  (pred_pc_cur),
        .pred_ins_cur (pred_ins_cur),
        .pred_pc_next (pred_pc_next),
        .pred_jump    (pred_jump),
        .iq_full      (iq_full),
        .out_valid    (out_valid),
        .out_ins      (out_ins),
        .out_pc       (out_pc),
        .out_pred_jump(out_pred_jump),
        .rob_flush    (rob_flush),
        .rob_flush_pc (rob_flush_pc)
    );

`ifdef FETCH_JALR_STALL_EN
    localparam bit JalrEn = 1'b1;
`else
    localparam bit JalrEn = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        pred_mode = 1'b0;
    logic        jalr_on = 1'b0;
    logic [31:0] jalr_addr = 32'h0;

    // Environment: memory contents and predictor behaviour.
    function automatic logic [31:0] ins_at(input logic [31:0] a, input logic jon,
                                           input logic [31:0] ja);
        if (jon && a == ja) return {a[24:0], 7'b1100111};
        return {a[26:2] ^ 25'h0A5_5A5A, 7'b0010011};
    endfunction

    function automatic logic pj_fn(input logic mode, input logic [31:0] ins);
        return mode && (ins[7] ^ ins[10]);
    endfunction

    function automatic logic [31:0] pn_fn(input logic mode, input logic [31:0] pc,
                                          input logic [31:0] ins);
        return pc + (pj_fn(mode, ins) ? 32'h40 : 32'h4);
    endfunction

    assign pred_jump    = pj_fn(pred_mode, pred_ins_cur);
    assign pred_pc_next = pn_fn(pred_mode, pred_pc_cur, pred_ins_cur);

    // Reference model: one outstanding request, an optional parked instruction, flags.
    logic [31:0] m_pc, m_req_addr, m_h_ins, m_h_next;
    logic        m_busy, m_stale, m_pend, m_h_jump, m_jwait;
    int          m_wait, m_lat;

    task automatic model_reset();
        m_pc = 32'h0; m_req_addr = 32'h0; m_h_ins = 32'h0; m_h_next = 32'h0;
        m_busy = 1'b0; m_stale = 1'b0; m_pend = 1'b0; m_h_jump = 1'b0; m_jwait = 1'b0;
        m_wait = 0; m_lat = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs at negedge, check against the model, advance the model.
    task automatic drive(input logic r_rst, input logic r_rdy, input logic r_fl,
                         input logic [31:0] r_fpc, input logic r_iv, input logic r_full);
        logic        e_v, e_jump;
        logic [31:0] e_ins, e_pc, ins;
        @(negedge clk);
        cyc++;
        ins          = ins_at(m_req_addr, jalr_on, jalr_addr);
        rst          = r_rst;
        rdy          = r_rdy;
        rob_flush    = r_fl;
        rob_flush_pc = r_fpc;
        iq_full      = r_full;
        icache_valid = r_iv;
        icache_ins   = r_iv ? ins : $urandom();
        #1;
        e_v = 1'b0; e_ins = 32'h0; e_pc = 32'h0; e_jump = 1'b0;
        if (m_pend) begin
            e_v = !r_full; e_ins = m_h_ins; e_pc = m_pc; e_jump = m_h_jump;
        end else if (m_busy && !m_stale && r_iv) begin
            e_v = !r_full; e_ins = ins; e_pc = m_pc; e_jump = pj_fn(pred_mode, ins);
        end
        if (!r_rdy || r_fl) e_v = 1'b0;
        chk("m_req", {31'b0, icache_req}, {31'b0, m_busy});
        if (m_busy) chk("m_addr", icache_addr, m_req_addr);
        chk("m_valid", {31'b0, out_valid}, {31'b0, e_v});
        if (e_v) begin
            chk("m_ins", out_ins, e_ins);
            chk("m_pc", out_pc, e_pc);
            chk("m_jump", {31'b0, out_pred_jump}, {31'b0, e_jump});
        end
        if (r_rst) begin
            model_reset();
        end else if (r_rdy) begin
            if (r_fl) begin
                if (m_busy && !r_iv) m_stale = 1'b1;
                else begin m_busy = 1'b0; m_stale = 1'b0; end
                m_pc = r_fpc; m_pend = 1'b0; m_jwait = 1'b0;
            end else if (m_busy && m_stale) begin
                if (r_iv) begin m_busy = 1'b0; m_stale = 1'b0; end
            end else if (m_busy) begin
                if (r_iv && !r_full) begin
                    m_pc = pn_fn(pred_mode, m_pc, ins);
                    if (JalrEn && ins[6:0] == 7'b1100111) begin
                        m_busy = 1'b0; m_jwait = 1'b1;
                    end else m_req_addr = m_pc;
                end else if (r_iv) begin
                    m_pend = 1'b1; m_h_ins = ins; m_busy = 1'b0;
                    m_h_next = pn_fn(pred_mode, m_pc, ins); m_h_jump = pj_fn(pred_mode, ins);
                end
            end else if (m_pend) begin
                if (!r_full) begin
                    m_pend = 1'b0; m_pc = m_h_next;
                    if (JalrEn && m_h_ins[6:0] == 7'b1100111) m_jwait = 1'b1;
                end
            end else if (!m_jwait) begin
                m_busy = 1'b1; m_req_addr = m_pc;
            end
        end
    endtask

    task automatic dchk(input logic e_req, input logic [31:0] e_addr, input logic e_v,
                        input logic [31:0] e_pc);
        chk("d_req", {31'b0, icache_req}, {31'b0, e_req});
        if (e_req) chk("d_addr", icache_addr, e_addr);
        chk("d_valid", {31'b0, out_valid}, {31'b0, e_v});
        if (e_v) chk("d_pc", out_pc, e_pc);
    endtask

    typedef struct {
        logic        iv;
        logic        full;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_jump;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic r_rdy, r_fl, r_full, r_iv;
        logic [31:0] r_fpc;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h4, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b0, 32'h0, 1'b0};

        rst = 1'b1; rdy = 1'b1; rob_flush = 1'b0; rob_flush_pc = 32'h0;
        iq_full = 1'b0; icache_valid = 1'b0; icache_ins = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, icache_req}, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_ins", out_ins, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_jump", {31'b0, out_pred_jump}, 32'h0);
        chk("rst_pc", pred_pc_cur, 32'h0);

        // Straight-line fetch, then a 3-cycle dispatcher stall on 0x8.
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, vecs[i].iv, vecs[i].full);
            dchk(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v, vecs[i].e_pc);
            if (vecs[i].e_v) chk("d_jump", {31'b0, out_pred_jump}, {31'b0, vecs[i].e_jump});
        end

        // Flush with 0x10 outstanding; stale response two cycles later is dropped.
        drive(0, 1, 0, 32'h0, 1, 0);           dchk(1, 32'hC, 1, 32'hC);
        drive(0, 1, 1, 32'h100, 0, 0);         dchk(1, 32'h10, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(1, 32'h10, 0, 0);
        drive(0, 1, 0, 32'h0, 1, 0);           dchk(1, 32'h10, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(1, 32'h100, 0, 0);
        // Flush colliding with the response.
        drive(0, 1, 1, 32'h100, 1, 0);         dchk(1, 32'h100, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(1, 32'h100, 0, 0);
        // rdy low for 4 cycles mid-fetch.
        drive(0, 0, 0, 32'h0, 0, 0);           dchk(1, 32'h100, 0, 0);
        drive(0, 0, 0, 32'h0, 1, 0);           dchk(1, 32'h100, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);           dchk(1, 32'h100, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);           dchk(1, 32'h100, 0, 0);
        drive(0, 1, 0, 32'h0, 1, 0);           dchk(1, 32'h100, 1, 32'h100);
        // PC wrap at the top of the address space.
        drive(0, 1, 1, 32'hFFFF_FFF8, 0, 0);   dchk(1, 32'h104, 0, 0);
        drive(0, 1, 0, 32'h0, 1, 0);           dchk(1, 32'h104, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 1, 0);           dchk(1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8);
        drive(0, 1, 0, 32'h0, 1, 0);           dchk(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(1, 32'h0, 0, 0);
        // JALR at 0x20.
        jalr_on = 1'b1; jalr_addr = 32'h20;
        drive(0, 1, 1, 32'h20, 1, 0);          dchk(1, 32'h0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(1, 32'h20, 0, 0);
        drive(0, 1, 0, 32'h0, 1, 0);           dchk(1, 32'h20, 1, 32'h20);
        chk("d_jalr_ins", out_ins[6:0], 7'b1100111);
`ifdef FETCH_JALR_STALL_EN
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(0, 0, 0, 0);
        drive(0, 1, 1, 32'h40, 0, 0);          dchk(0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(0, 0, 0, 0);
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(1, 32'h40, 0, 0);
`else
        drive(0, 1, 0, 32'h0, 0, 0);           dchk(1, 32'h24, 0, 0);
`endif
        jalr_on = 1'b0;

        // Randomized traffic with a variable-latency cache and jumping predictor.
        pred_mode = 1'b1;
        m_wait = 0; m_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            r_rdy  = ($urandom_range(0, 9) != 0);
            r_fl   = ($urandom_range(0, 19) == 0);
            r_full = ($urandom_range(0, 2) == 0);
            r_fpc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
            r_iv   = r_rdy && m_busy && (m_wait >= m_lat);
            if (r_rdy && m_busy) begin
                if (r_iv) begin m_wait = 0; m_lat = $urandom_range(0, 2); end
                else m_wait++;
            end
            drive(1'b0, r_rdy, r_fl, r_fpc, r_iv, r_full);
        end

        // Reset while rdy is low must still take effect.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        dchk(0, 0, 0, 0);
        chk("rst_rdy_pc", pred_pc_cur, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        dchk(1, 32'h0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        dchk(1, 32'h0, 1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
